// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer and its control circuit / ROM.
// The slave modport is the sequencer's view of the bus; the master modport is the environment's view.
interface instr_sequencer_if;
  logic       Start;
  logic [4:0] Program_len;
  logic       Done;
  logic [7:0] Rom_data;
  logic [3:0] Rom_addr;
  logic [7:0] Opcode;
  logic       isRomDone;
  logic       Prog_end;
  logic [4:0] Pc;

  modport slave (
    input  Start, Program_len, Done, Rom_data,
    output Rom_addr, Opcode, isRomDone, Prog_end, Pc
  );

  modport master (
    output Start, Program_len, Done, Rom_data,
    input  Rom_addr, Opcode, isRomDone, Prog_end, Pc
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches opcodes from a synchronous ROM and hands them one at a time to a control circuit.
// Optional macro SEQ_LOOP_EN: after the last instruction, restart at Pc=0 with a one-cycle Prog_end pulse instead of stopping.
module instr_sequencer (
  input  logic                Clock,
  input  logic                Reset,
  instr_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WAIT,
    S_END
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [3:0] rom_addr_q, rom_addr_d;
  logic [7:0] opcode_q, opcode_d;
  logic       rom_done_q, rom_done_d;
  logic       prog_end_q, prog_end_d;
  logic [4:0] len_q, len_d;

  logic [4:0] len_sat;
  logic [4:0] pc_inc;

  assign len_sat = (bus.Program_len > 5'd16) ? 5'd16 : bus.Program_len;
  assign pc_inc  = pc_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    rom_done_d = rom_done_q;
    prog_end_d = prog_end_q;
    len_d      = len_q;

    unique case (state_q)
      S_IDLE, S_END: begin
        if (bus.Start) begin
          if (bus.Program_len == 5'd0) begin
            // Empty program completes immediately without ever presenting an opcode.
            state_d    = S_END;
            prog_end_d = 1'b1;
          end else begin
            pc_d       = '0;
            prog_end_d = 1'b0;
            len_d      = len_sat;
            state_d    = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        prog_end_d = 1'b0;
        state_d    = S_LATCH;
      end

      S_LATCH: begin
        opcode_d   = bus.Rom_data;
        rom_done_d = 1'b0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (bus.Done) begin
          rom_done_d = 1'b1;
          if (pc_inc < len_q) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            prog_end_d = 1'b1;
`ifdef SEQ_LOOP_EN
            pc_d       = '0;
            state_d    = S_FETCH;
`else
            pc_d       = len_q;
            state_d    = S_END;
`endif
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // The ROM address is a registered copy of the low Pc bits so it is valid at the FETCH edge.
  assign rom_addr_d = pc_d[3:0];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      rom_addr_q <= '0;
      opcode_q   <= '0;
      rom_done_q <= 1'b1;
      prog_end_q <= 1'b0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rom_addr_q <= rom_addr_d;
      opcode_q   <= opcode_d;
      rom_done_q <= rom_done_d;
      prog_end_q <= prog_end_d;
      len_q      <= len_d;
    end
  end

  assign bus.Rom_addr  = rom_addr_q;
  assign bus.Opcode    = opcode_q;
  assign bus.isRomDone = rom_done_q;
  assign bus.Prog_end  = prog_end_q;
  assign bus.Pc        = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed vector table, hand-written corner sequences, and random
// stimulus compared every cycle against a transaction-level reference model.
module tb_instr_sequencer;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  instr_sequencer_if bus ();

  instr_sequencer dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  logic [7:0] rom [16];
  always @(posedge Clock) bus.Rom_data <= rom[bus.Rom_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a program run is "running" with a countdown of edges until the
  // next opcode lands; once it lands the model waits for Done.
  int         m_pc, m_len, m_cd;
  bit         m_run, m_valid, m_end;
  logic [7:0] m_op;

  task automatic m_reset();
    m_pc = 0; m_len = 0; m_cd = 0;
    m_run = 0; m_valid = 0; m_end = 0; m_op = 8'h00;
  endtask

  task automatic model_edge();
    if (!Reset) begin
      m_reset();
    end else if (!m_run) begin
      if (bus.Start) begin
        if (bus.Program_len == 0) m_end = 1;
        else begin
          m_pc  = 0;
          m_end = 0;
          m_len = (bus.Program_len > 16) ? 16 : int'(bus.Program_len);
          m_cd  = 2;
          m_run = 1;
        end
      end
    end else begin
      m_end = 0;
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          m_op    = rom[m_pc % 16];
          m_valid = 1;
        end
      end else if (bus.Done) begin
        m_valid = 0;
        if (m_pc + 1 < m_len) begin
          m_pc++;
          m_cd = 2;
        end else begin
          m_end = 1;
`ifdef SEQ_LOOP_EN
          m_pc = 0;
          m_cd = 2;
`else
          m_pc  = m_len;
          m_run = 0;
`endif
        end
      end
    end
  endtask

  task automatic cmp_model();
    chk("mdl_isRomDone", bus.isRomDone, !m_valid);
    chk("mdl_Prog_end",  bus.Prog_end,  m_end);
    chk("mdl_Pc",        bus.Pc,        m_pc);
    chk("mdl_Rom_addr",  bus.Rom_addr,  m_pc % 16);
    chk("mdl_Opcode",    bus.Opcode,    m_op);
  endtask

  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
    cmp_model();
  endtask

  task automatic drive(input logic st, input logic [4:0] ln, input logic dn);
    bus.Start = st;
    bus.Program_len = ln;
    bus.Done = dn;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_isRomDone"}, bus.isRomDone, 1);
    chk({tag, "_Prog_end"},  bus.Prog_end,  0);
    chk({tag, "_Pc"},        bus.Pc,        0);
    chk({tag, "_Rom_addr"},  bus.Rom_addr,  0);
    chk({tag, "_Opcode"},    bus.Opcode,    0);
  endtask

  typedef struct {
    logic       start;
    logic [4:0] len;
    logic       done;
    logic       rdone;
    logic       pend;
    logic [4:0] pc;
    logic [3:0] addr;
    logic [7:0] op;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [4:0] ln, input logic dn,
                              input logic rd, input logic pe, input logic [4:0] pc,
                              input logic [3:0] ad, input logic [7:0] op);
    vec_t v;
    v.start = st; v.len = ln; v.done = dn;
    v.rdone = rd; v.pend = pe; v.pc = pc; v.addr = ad; v.op = op;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'(8'h10 + i * 7);
    rom[0] = 8'h05; rom[1] = 8'h41; rom[2] = 8'hC4;
    bus.Rom_data = 8'h00;
    drive(0, 5'd0, 0);
    m_reset();

    // Three-instruction program; Done is also raised where it must be ignored.
    tbl[0]  = mk(1, 5'd3, 1, 1, 0, 5'd0, 4'd0, 8'h00);
    tbl[1]  = mk(0, 5'd3, 1, 1, 0, 5'd0, 4'd0, 8'h00);
    tbl[2]  = mk(0, 5'd0, 1, 0, 0, 5'd0, 4'd0, 8'h05);
    tbl[3]  = mk(1, 5'd0, 0, 0, 0, 5'd0, 4'd0, 8'h05);
    tbl[4]  = mk(0, 5'd0, 1, 1, 0, 5'd1, 4'd1, 8'h05);
    tbl[5]  = mk(0, 5'd0, 1, 1, 0, 5'd1, 4'd1, 8'h05);
    tbl[6]  = mk(0, 5'd0, 1, 0, 0, 5'd1, 4'd1, 8'h41);
    tbl[7]  = mk(0, 5'd0, 1, 1, 0, 5'd2, 4'd2, 8'h41);
    tbl[8]  = mk(0, 5'd0, 0, 1, 0, 5'd2, 4'd2, 8'h41);
    tbl[9]  = mk(0, 5'd0, 0, 0, 0, 5'd2, 4'd2, 8'hC4);
    tbl[10] = mk(0, 5'd0, 0, 0, 0, 5'd2, 4'd2, 8'hC4);
`ifdef SEQ_LOOP_EN
    tbl[11] = mk(0, 5'd0, 1, 1, 1, 5'd0, 4'd0, 8'hC4);
    tbl[12] = mk(0, 5'd0, 1, 1, 0, 5'd0, 4'd0, 8'hC4);
    tbl[13] = mk(0, 5'd0, 0, 0, 0, 5'd0, 4'd0, 8'h05);
`else
    tbl[11] = mk(0, 5'd0, 1, 1, 1, 5'd3, 4'd3, 8'hC4);
    tbl[12] = mk(0, 5'd0, 1, 1, 1, 5'd3, 4'd3, 8'hC4);
    tbl[13] = mk(0, 5'd0, 0, 1, 1, 5'd3, 4'd3, 8'hC4);
`endif

    tick();
    tick();
    chk_reset_vals("rst");
    Reset = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].start, tbl[i].len, tbl[i].done);
      tick();
      chk($sformatf("tbl%0d_isRomDone", i), bus.isRomDone, tbl[i].rdone);
      chk($sformatf("tbl%0d_Prog_end", i),  bus.Prog_end,  tbl[i].pend);
      chk($sformatf("tbl%0d_Pc", i),        bus.Pc,        tbl[i].pc);
      chk($sformatf("tbl%0d_Rom_addr", i),  bus.Rom_addr,  tbl[i].addr);
      chk($sformatf("tbl%0d_Opcode", i),    bus.Opcode,    tbl[i].op);
    end

    // Empty program: straight to END, no opcode ever presented.
    drive(0, 5'd0, 0);
    Reset = 1'b0; m_reset();
    tick();
    Reset = 1'b1;
    tick();
    drive(1, 5'd0, 0);
    tick();
    chk("len0_Prog_end",  bus.Prog_end,  1);
    chk("len0_isRomDone", bus.isRomDone, 1);
    chk("len0_Rom_addr",  bus.Rom_addr,  0);
    drive(0, 5'd0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("len0_hold_isRomDone", bus.isRomDone, 1);
    end

    // Done held high through a four-instruction run, then asynchronous reset while waiting at Pc=2.
    drive(1, 5'd4, 1);
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("held_Pc",        bus.Pc,        2);
    chk("held_Opcode",    bus.Opcode,    8'hC4);
    chk("held_isRomDone", bus.isRomDone, 0);
    bus.Done = 1'b0;
    #1;
    Reset = 1'b0; m_reset();
    #1;
    chk_reset_vals("async");
    #1;
    Reset = 1'b1;
    tick();
    drive(1, 5'd4, 0);
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
    chk("restart_Opcode",    bus.Opcode,    8'h05);
    chk("restart_isRomDone", bus.isRomDone, 0);

    // Oversized length saturates to 16 instructions.
    drive(0, 5'd0, 0);
    Reset = 1'b0; m_reset();
    tick();
    Reset = 1'b1;
    drive(1, 5'd20, 1);
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 51; i++) tick();
`ifndef SEQ_LOOP_EN
    chk("sat_Pc",       bus.Pc,       16);
    chk("sat_Rom_addr", bus.Rom_addr, 0);
    chk("sat_Prog_end", bus.Prog_end, 1);
`endif

    for (int i = 0; i < 4000; i++) begin
      bus.Start = ($urandom % 8) == 0;
      bus.Program_len = ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      bus.Done = ($urandom % 2) == 0;
      if ($urandom % 300 == 0) begin
        Reset = 1'b0;
        m_reset();
      end else begin
        Reset = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port: Clock  input  1  system clock, rising-edge.
REQ-002 SHALL have port: Reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: Start  input  1  begin program run; sampled in IDLE or END only.
REQ-004 SHALL have port: Program_len  input  5  instruction count, 0..16; latched on accepted Start.
REQ-005 SHALL have port: Done  input  1  one-cycle completion pulse from the control circuit.
REQ-006 SHALL have port: Rom_data  input  8  synchronous ROM read data, valid one cycle after Rom_addr is sampled.
REQ-007 SHALL have port: Rom_addr  output  4  registered ROM address, equal to Pc.
REQ-008 SHALL have port: Opcode  output  8  registered instruction presented to the control circuit.
REQ-009 SHALL have port: isRomDone  output  1  registered; 0 means Opcode is valid and held, 1 means no instruction is pending.
REQ-010 SHALL have port: Prog_end  output  1  registered; 1 means the program is complete.
REQ-011 SHALL have port: Pc  output  5  registered instruction index, 0..16.

Function
REQ-012 SHALL implement states IDLE, FETCH, LATCH, WAIT and END.
REQ-013 In IDLE or END, Start=1 at edge E: Pc<=0, Rom_addr<=0, Prog_end<=0, Len<=Program_len, state<=FETCH, unless Program_len=0.
REQ-014 In IDLE or END, Start=1 with Program_len=0: state<=END, Prog_end<=1, isRomDone stays 1.
REQ-015 FETCH is the ROM address-sampling cycle: state<=LATCH unconditionally.
REQ-016 LATCH: Opcode<=Rom_data, isRomDone<=0, state<=WAIT; Opcode is valid two edges after the accepted Start edge.
REQ-017 WAIT: Opcode and isRomDone=0 SHALL be held stable until Done=1 is sampled.
REQ-018 WAIT with Done=1 at edge E and Pc+1<Len: Pc<=Pc+1, Rom_addr<=Pc+1, isRomDone<=1, state<=FETCH; next Opcode is valid after edge E+2.
REQ-019 WAIT with Done=1 and Pc+1=Len: Pc<=Len, isRomDone<=1, Prog_end<=1, state<=END.
REQ-020 Done SHALL be ignored in every state except WAIT; Start SHALL be ignored in FETCH, LATCH and WAIT.
REQ-021 Done held high for several cycles SHALL advance exactly once per WAIT entry.
REQ-022 END SHALL hold Prog_end=1, isRomDone=1, and Opcode at the last value.
REQ-023 Program_len values 17..31 SHALL be saturated to 16 when latched.
REQ-024 Pc arithmetic is 5-bit; Rom_addr = Pc[3:0] and never exceeds 15 when a fetch is issued.
REQ-025 The isRomDone rising edge SHALL occur in the cycle after Done is sampled, before the control circuit returns to its ROM-wait state.

Reset
REQ-026 Reset=0 SHALL force, asynchronously: state=IDLE, Pc=0, Rom_addr=0, Opcode=8'h00, isRomDone=1, Prog_end=0, Len=0.
REQ-027 Reset asserted mid-program SHALL abandon the run; the sequencer resumes only on a new Start after Reset is released.

Configuration
REQ-028 Macro SEQ_LOOP_EN: when defined, completing the last instruction SHALL set Pc<=0 and Rom_addr<=0, pulse Prog_end high for one cycle, and go to FETCH (continuous loop); Start is still ignored while running.
REQ-029 Without SEQ_LOOP_EN: behaviour per REQ-019 and REQ-022 (stop in END).

Verification
REQ-030 Reset, then Start with Program_len=3 and ROM={8'h05,8'h41,8'hC4}: Opcode=05 with isRomDone=0 two edges after Start; each Done pulse yields the next opcode two edges later; after the third Done, Prog_end=1 and Pc=3.
REQ-031 Program_len=0 with Start: END entered next edge, Prog_end=1, isRomDone never 0, Rom_addr stays 0.
REQ-032 Done pulses in IDLE, FETCH and LATCH, and Start pulses in WAIT: no change to Pc or Opcode.
REQ-033 Done held high for 5 cycles in WAIT with Program_len=4: Pc advances by exactly 1 per WAIT entry.
REQ-034 Reset pulsed low while in WAIT at Pc=2: all outputs return to reset values immediately; a new Start refetches ROM[0].
REQ-035 SEQ_LOOP_EN defined, Program_len=2: after the second Done, Rom_addr=0, Prog_end pulses for 1 cycle, and Opcode=ROM[0] reappears two edges later.
